pmcc_code_mem: RTL and testbench
================================

# pmcc_code_mem

Parametrised dual-port code memory for the pixel-matrix controller core (PMCC). It replaces the fixed 1 k-word code RAM with a block of configurable depth, base address and read latency. Port A is an Ibex data-bus slave used by the SoC to load and read back PMCC firmware. Port B is a handshaked instruction-fetch port for the PMCC core, with write-to-fetch forwarding, address-range checking and a firmware write lock.

## Interface
Parameters:
- ADDR_WIDTH, 10: word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte base of the window on port A; must be aligned to 4*2**ADDR_WIDTH.
- READ_LATENCY, 1: cycles from accepted request to response; legal values 1 or 2.
- INSTR_RESET, 32'h0000_0013: reset/idle value of instr (RV32 NOP).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- data_bus  ibex_data_bus.slave  -  port A: req, gnt, rvalid, err, we, be[3:0], addr[31:0], wdata[31:0], rdata[31:0].
- fetch_req  in  1  instruction fetch request.
- fetch_addr  in  ADDR_WIDTH  word address of the fetch.
- instr  out  32  fetched instruction.
- instr_valid  out  1  instr holds the response to a fetch.
- wr_lock  in  1  when 1, port A writes are rejected.

## Operation
- Storage: 2**ADDR_WIDTH x 32 array. No reset of contents.
- Port A decode: word index = addr[ADDR_WIDTH+1:2]. The access is in range when addr[31:ADDR_WIDTH+2] equals BASE_ADDR[31:ADDR_WIDTH+2].
- gnt = req, combinational. Every request is accepted in the cycle it is presented.
- Accepted write, in range, wr_lock=0: bytes with be[i]=1 are written. err=0 on the response.
- Accepted write, out of range or wr_lock=1: memory is unchanged. Response has err=1.
- Accepted read, in range: the response carries the word in rdata with err=0.
- Accepted read, out of range: the response has rdata=0 and err=1.
- Every accepted request, read or write, produces exactly one rvalid pulse.
- rdata is only defined while rvalid=1. Between responses it holds its last value.
- Port B: fetch_req=1 launches a read of fetch_addr. Port B has no range check and no error.
- Collision: a port A write and a port B fetch to the same word in the same cycle are resolved write-first. instr returns the old word merged with the written bytes (per be).
- Port A read and port B fetch of the same word in the same cycle both return the stored value.
- Pipeline for READ_LATENCY=2: one extra register stage on rdata/err/rvalid and on instr/instr_valid. Forwarding is resolved at the array stage.

## Timing
- Reset values: rvalid=0, err=0, rdata=0, instr=INSTR_RESET, instr_valid=0.
- While rst_n=0, all in-flight responses are flushed; none appears after reset deasserts.
- A port A request accepted on edge N gives rvalid=1 (and err, rdata) during cycle N+READ_LATENCY, for one cycle.
- Back-to-back requests give back-to-back rvalid pulses, in order.
- A fetch accepted on edge N gives instr and instr_valid=1 during cycle N+READ_LATENCY.
- instr_valid is 0 for cycles with no corresponding fetch. instr holds its last value, or INSTR_RESET if no fetch has completed since reset.
- wr_lock is sampled in the cycle the write is accepted. A change takes effect on the next request.
- Write visibility: a word written on edge N is returned by a fetch or read accepted on edge N+1 or later. A fetch on edge N itself sees it through forwarding.

## Test plan
- Load/readback: write 0xDEADBEEF to BASE+0x10 with be=4'hF, then read it back. Expect rvalid at +READ_LATENCY with rdata=0xDEADBEEF and err=0; fetch_addr=4 gives instr=0xDEADBEEF.
- Byte enables: preload 0x11223344, write 0xAABBCCDD with be=4'b0101. The readback is 0x11BB33DD.
- Range/lock: a read at BASE+4*2**ADDR_WIDTH gives err=1 and rdata=0. A write with wr_lock=1 gives err=1, and the word is unchanged on readback.
- Collision: the word holds 0x0; a same-cycle write of 0x12345678 (be=4'b0011) and a fetch of that word give instr=0x00005678.
- Streaming: 8 consecutive fetches plus 8 consecutive port A reads, run for READ_LATENCY=1 and 2. Expect 8 contiguous instr_valid and rvalid pulses, in order, with correct data and exact latency.
- Reset mid-flight: assert rst_n=0 one cycle after a request (READ_LATENCY=2). No rvalid or instr_valid appears, and instr=0x00000013 after reset.

Source files
------------

// File: rtl/pmcc_code_mem_if.sv
// Ibex-style data bus used by the SoC to load and read back PMCC firmware.
// The master drives the request side; the slave answers with grant and response.
interface ibex_data_bus;
   logic        req;
   logic        gnt;
   logic        rvalid;
   logic        err;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, err, rdata
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, err, rdata
   );
endinterface

// File: rtl/pmcc_code_mem.sv
// Dual-port PMCC code memory.
// Port A is an SoC data-bus slave for loading and reading back firmware.
// Port B is the instruction-fetch port of the PMCC core. A port A write and a
// port B fetch of the same word in the same cycle return the freshly written
// bytes to the fetch (write-first).
// Any READ_LATENCY other than 2 builds the single-cycle pipeline.
module pmcc_code_mem #(
   parameter int          ADDR_WIDTH   = 10,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] INSTR_RESET  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   ibex_data_bus.slave           data_bus,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   input  logic                  wr_lock
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   // Storage array. Its contents are never reset.
   logic [31:0] mem [DEPTH];

   // Port A decode and fetch-path forwarding signals
   logic [ADDR_WIDTH-1:0] a_idx;
   logic                  a_in_range;
   logic                  a_wr_ok;
   logic                  a_bad;
   logic [31:0]           be_mask;
   logic [31:0]           a_old;
   logic [31:0]           a_merged;
   logic [31:0]           fetch_word;
   logic [1:0]            unused_addr_bits;

   // Array-stage pipeline registers
   logic        a_vld1_d, a_vld1_q;
   logic        a_err1_d, a_err1_q;
   logic [31:0] a_rdata1_d, a_rdata1_q;
   logic        b_vld1_d, b_vld1_q;
   logic [31:0] b_instr1_d, b_instr1_q;

   // The bus accepts every request in the cycle it is presented
   assign data_bus.gnt     = data_bus.req;
   assign unused_addr_bits = data_bus.addr[1:0];

   // Decode port A, build the byte mask, and forward a colliding write into the fetch
   always_comb begin
      a_idx      = data_bus.addr[ADDR_WIDTH+1:2];
      a_in_range = (data_bus.addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
      be_mask    = {{8{data_bus.be[3]}}, {8{data_bus.be[2]}},
                    {8{data_bus.be[1]}}, {8{data_bus.be[0]}}};
      // Writes are suppressed while in reset, since their responses are flushed
      a_wr_ok    = rst_n && data_bus.req && data_bus.we && a_in_range && !wr_lock;
      a_bad      = !a_in_range || (data_bus.we && wr_lock);
      a_old      = mem[a_idx];
      a_merged   = (a_old & ~be_mask) | (data_bus.wdata & be_mask);
      fetch_word = mem[fetch_addr];
      if (a_wr_ok && (fetch_addr == a_idx)) begin
         fetch_word = (fetch_word & ~be_mask) | (data_bus.wdata & be_mask);
      end
   end

   // Byte-masked array write from port A
   always_ff @(posedge clk) begin
      if (a_wr_ok) begin
         mem[a_idx] <= a_merged;
      end
   end

   // Next values of the array-stage registers; read data holds between read responses
   always_comb begin
      a_vld1_d   = data_bus.req;
      a_err1_d   = data_bus.req && a_bad;
      a_rdata1_d = a_rdata1_q;
      if (data_bus.req && !data_bus.we) begin
         a_rdata1_d = a_in_range ? a_old : 32'h0;
      end
      b_vld1_d   = fetch_req;
      b_instr1_d = fetch_req ? fetch_word : b_instr1_q;
   end

   // Array-stage registers; synchronous reset flushes anything in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_vld1_q   <= 1'b0;
         a_err1_q   <= 1'b0;
         a_rdata1_q <= 32'h0;
         b_vld1_q   <= 1'b0;
         b_instr1_q <= INSTR_RESET;
      end else begin
         a_vld1_q   <= a_vld1_d;
         a_err1_q   <= a_err1_d;
         a_rdata1_q <= a_rdata1_d;
         b_vld1_q   <= b_vld1_d;
         b_instr1_q <= b_instr1_d;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      logic        a_vld2_d, a_vld2_q;
      logic        a_err2_d, a_err2_q;
      logic [31:0] a_rdata2_d, a_rdata2_q;
      logic        b_vld2_d, b_vld2_q;
      logic [31:0] b_instr2_d, b_instr2_q;

      // Output stage: data moves on only with a response, so it holds otherwise
      always_comb begin
         a_vld2_d   = a_vld1_q;
         a_err2_d   = a_err1_q;
         a_rdata2_d = a_vld1_q ? a_rdata1_q : a_rdata2_q;
         b_vld2_d   = b_vld1_q;
         b_instr2_d = b_vld1_q ? b_instr1_q : b_instr2_q;
      end

      // Output-stage registers, flushed by reset like the array stage
      always_ff @(posedge clk) begin
         if (!rst_n) begin
            a_vld2_q   <= 1'b0;
            a_err2_q   <= 1'b0;
            a_rdata2_q <= 32'h0;
            b_vld2_q   <= 1'b0;
            b_instr2_q <= INSTR_RESET;
         end else begin
            a_vld2_q   <= a_vld2_d;
            a_err2_q   <= a_err2_d;
            a_rdata2_q <= a_rdata2_d;
            b_vld2_q   <= b_vld2_d;
            b_instr2_q <= b_instr2_d;
         end
      end

      assign data_bus.rvalid = a_vld2_q;
      assign data_bus.err    = a_err2_q;
      assign data_bus.rdata  = a_rdata2_q;
      assign instr_valid     = b_vld2_q;
      assign instr           = b_instr2_q;
   end else begin : g_lat1
      assign data_bus.rvalid = a_vld1_q;
      assign data_bus.err    = a_err1_q;
      assign data_bus.rdata  = a_rdata1_q;
      assign instr_valid     = b_vld1_q;
      assign instr           = b_instr1_q;
   end

endmodule

// File: tb/tb_pmcc_code_mem.sv
// Directed bench for pmcc_code_mem: one instance with READ_LATENCY=1 and one with 2.
module tb_pmcc_code_mem;

   localparam int          AW    = 6;
   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic        Y     = 1'b1;
   localparam logic        N     = 1'b0;

   typedef struct {
      logic          req;
      logic          we;
      logic [3:0]    be;
      logic [31:0]   addr;
      logic [31:0]   wdata;
      logic          freq;
      logic [AW-1:0] faddr;
      logic          lock;
      logic          e_rv;
      logic          e_err;
      logic          c_rd;
      logic [31:0]   e_rd;
      logic          e_iv;
      logic          c_in;
      logic [31:0]   e_in;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;

   ibex_data_bus bus1 ();
   ibex_data_bus bus2 ();

   logic          fetch_req1, fetch_req2;
   logic [AW-1:0] fetch_addr1, fetch_addr2;
   logic [31:0]   instr1, instr2;
   logic          instr_valid1, instr_valid2;
   logic          wr_lock1, wr_lock2;

   int total = 0;
   int bad   = 0;

   vec_t vecs [18];

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   pmcc_code_mem #(
      .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(1), .INSTR_RESET(NOP)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .data_bus(bus1.slave),
      .fetch_req(fetch_req1), .fetch_addr(fetch_addr1),
      .instr(instr1), .instr_valid(instr_valid1), .wr_lock(wr_lock1)
   );

   pmcc_code_mem #(
      .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .READ_LATENCY(2), .INSTR_RESET(NOP)
   ) u_dut2 (
      .clk(clk), .rst_n(rst_n), .data_bus(bus2.slave),
      .fetch_req(fetch_req2), .fetch_addr(fetch_addr2),
      .instr(instr2), .instr_valid(instr_valid2), .wr_lock(wr_lock2)
   );

   function automatic logic [31:0] streamWord(input int i);
      return 32'hC0DE_0000 + 32'(i * 32'h0000_0101);
   endfunction

   function automatic vec_t mk(
      input logic req, input logic we, input logic [3:0] be,
      input logic [31:0] addr, input logic [31:0] wdata,
      input logic freq, input logic [AW-1:0] faddr, input logic lock,
      input logic e_rv, input logic e_err, input logic c_rd, input logic [31:0] e_rd,
      input logic e_iv, input logic c_in, input logic [31:0] e_in);
      vec_t v;
      v.req = req; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
      v.freq = freq; v.faddr = faddr; v.lock = lock;
      v.e_rv = e_rv; v.e_err = e_err; v.c_rd = c_rd; v.e_rd = e_rd;
      v.e_iv = e_iv; v.c_in = c_in; v.e_in = e_in;
      return v;
   endfunction

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs to the selected instance, check the combinational grant,
   // then advance to the next falling edge
   task automatic applyStimulus(
      input int sel, input logic req, input logic we, input logic [3:0] be,
      input logic [31:0] addr, input logic [31:0] wdata,
      input logic freq, input logic [AW-1:0] faddr, input logic lock);
      if (sel == 1) begin
         bus1.req = req; bus1.we = we; bus1.be = be; bus1.addr = addr; bus1.wdata = wdata;
         fetch_req1 = freq; fetch_addr1 = faddr; wr_lock1 = lock;
         #1 checkVal("gnt1", {31'h0, bus1.gnt}, {31'h0, req});
      end else begin
         bus2.req = req; bus2.we = we; bus2.be = be; bus2.addr = addr; bus2.wdata = wdata;
         fetch_req2 = freq; fetch_addr2 = faddr; wr_lock2 = lock;
         #1 checkVal("gnt2", {31'h0, bus2.gnt}, {31'h0, req});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int sel);
      applyStimulus(sel, N, N, 4'h0, 32'h0, 32'h0, N, '0, N);
   endtask

   task automatic checkOutput(
      input int sel, input string tag,
      input logic e_rv, input logic e_err, input logic c_rd, input logic [31:0] e_rd,
      input logic e_iv, input logic c_in, input logic [31:0] e_in);
      logic        rv, er, iv;
      logic [31:0] rd, in;
      if (sel == 1) begin
         rv = bus1.rvalid; er = bus1.err; rd = bus1.rdata; iv = instr_valid1; in = instr1;
      end else begin
         rv = bus2.rvalid; er = bus2.err; rd = bus2.rdata; iv = instr_valid2; in = instr2;
      end
      checkVal({tag, " rvalid"}, {31'h0, rv}, {31'h0, e_rv});
      checkVal({tag, " err"}, {31'h0, er}, {31'h0, e_err});
      if (c_rd) checkVal({tag, " rdata"}, rd, e_rd);
      checkVal({tag, " instr_valid"}, {31'h0, iv}, {31'h0, e_iv});
      if (c_in) checkVal({tag, " instr"}, in, e_in);
   endtask

   // Preload 8 words, then stream 8 reads and 8 fetches back to back with exact latency
   task automatic streamTest(input int sel, input int lat);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(sel, Y, Y, 4'hF, BASE + 32'(4 * i), streamWord(i), N, '0, N);
      end
      for (int i = 0; i < lat; i++) idle(sel);
      for (int c = 0; c < 9 + lat; c++) begin
         int k;
         if (c < 8) begin
            applyStimulus(sel, Y, N, 4'h0, BASE + 32'(4 * c), 32'h0, Y, AW'(7 - c), N);
         end else begin
            idle(sel);
         end
         k = c - lat + 1;
         if (k >= 0 && k < 8) begin
            checkOutput(sel, $sformatf("stream L%0d k%0d", lat, k),
                        Y, N, Y, streamWord(k), Y, Y, streamWord(7 - k));
         end else begin
            checkOutput(sel, $sformatf("stream L%0d gap c%0d", lat, c),
                        N, N, N, 32'h0, N, N, 32'h0);
         end
      end
   endtask

   initial begin
      // Table of single-cycle vectors run on the READ_LATENCY=1 instance
      vecs[0]  = mk(Y, Y, 4'hF, BASE + 32'h10, 32'hDEADBEEF, N, 6'd0, N,  Y, N, N, 32'h0,        N, Y, NOP);
      vecs[1]  = mk(Y, N, 4'h0, BASE + 32'h10, 32'h0,        Y, 6'd4, N,  Y, N, Y, 32'hDEADBEEF, Y, Y, 32'hDEADBEEF);
      vecs[2]  = mk(Y, Y, 4'hF, BASE + 32'h20, 32'h11223344, N, 6'd0, N,  Y, N, N, 32'h0,        N, Y, 32'hDEADBEEF);
      vecs[3]  = mk(Y, Y, 4'h5, BASE + 32'h20, 32'hAABBCCDD, N, 6'd0, N,  Y, N, N, 32'h0,        N, N, 32'h0);
      vecs[4]  = mk(Y, N, 4'h0, BASE + 32'h20, 32'h0,        N, 6'd0, N,  Y, N, Y, 32'h11BB33DD, N, N, 32'h0);
      vecs[5]  = mk(Y, N, 4'h0, BASE + 32'h100, 32'h0,       N, 6'd0, N,  Y, Y, Y, 32'h0,        N, N, 32'h0);
      vecs[6]  = mk(Y, Y, 4'hF, BASE + 32'h24, 32'h55555555, N, 6'd0, N,  Y, N, N, 32'h0,        N, N, 32'h0);
      vecs[7]  = mk(Y, Y, 4'hF, BASE + 32'h24, 32'hCAFEF00D, N, 6'd0, Y,  Y, Y, N, 32'h0,        N, N, 32'h0);
      vecs[8]  = mk(Y, N, 4'h0, BASE + 32'h24, 32'h0,        N, 6'd0, Y,  Y, N, Y, 32'h55555555, N, N, 32'h0);
      vecs[9]  = mk(Y, Y, 4'hF, 32'h0002_0020, 32'hFFFFFFFF, N, 6'd0, N,  Y, Y, N, 32'h0,        N, N, 32'h0);
      vecs[10] = mk(Y, N, 4'h0, BASE + 32'h20, 32'h0,        N, 6'd0, N,  Y, N, Y, 32'h11BB33DD, N, N, 32'h0);
      vecs[11] = mk(Y, Y, 4'hF, BASE + 32'h30, 32'h0,        N, 6'd0, N,  Y, N, N, 32'h0,        N, N, 32'h0);
      vecs[12] = mk(Y, Y, 4'h3, BASE + 32'h30, 32'h12345678, Y, 6'd12, N, Y, N, N, 32'h0,        Y, Y, 32'h00005678);
      vecs[13] = mk(Y, N, 4'h0, BASE + 32'h30, 32'h0,        Y, 6'd12, N, Y, N, Y, 32'h00005678, Y, Y, 32'h00005678);
      vecs[14] = mk(N, N, 4'h0, 32'h0,         32'h0,        N, 6'd0, N,  N, N, Y, 32'h00005678, N, Y, 32'h00005678);
      vecs[15] = mk(Y, N, 4'h0, BASE + 32'h10, 32'h0,        Y, 6'd4, N,  Y, N, Y, 32'hDEADBEEF, Y, Y, 32'hDEADBEEF);
      vecs[16] = mk(Y, N, 4'h0, 32'h0002_0010, 32'h0,        N, 6'd0, N,  Y, Y, Y, 32'h0,        N, N, 32'h0);
      vecs[17] = mk(N, N, 4'h0, 32'h0,         32'h0,        Y, 6'd9, N,  N, N, Y, 32'h0,        Y, Y, 32'h55555555);

      // Hold both instances in reset with idle inputs
      rst_n = 1'b0;
      bus1.req = N; bus1.we = N; bus1.be = 4'h0; bus1.addr = 32'h0; bus1.wdata = 32'h0;
      bus2.req = N; bus2.we = N; bus2.be = 4'h0; bus2.addr = 32'h0; bus2.wdata = 32'h0;
      fetch_req1 = N; fetch_addr1 = '0; wr_lock1 = N;
      fetch_req2 = N; fetch_addr2 = '0; wr_lock2 = N;
      repeat (3) @(negedge clk);
      checkOutput(1, "reset L1", N, N, Y, 32'h0, N, Y, NOP);
      checkOutput(2, "reset L2", N, N, Y, 32'h0, N, Y, NOP);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         applyStimulus(1, vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
                       vecs[i].freq, vecs[i].faddr, vecs[i].lock);
         checkOutput(1, $sformatf("vec%0d", i), vecs[i].e_rv, vecs[i].e_err, vecs[i].c_rd,
                     vecs[i].e_rd, vecs[i].e_iv, vecs[i].c_in, vecs[i].e_in);
      end
      idle(1);

      streamTest(1, 1);
      streamTest(2, 2);

      // Reset one cycle after a request on the two-stage instance flushes the response
      applyStimulus(2, Y, N, 4'h0, BASE, 32'h0, Y, '0, N);
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         idle(2);
         checkOutput(2, $sformatf("flush in reset %0d", i), N, N, Y, 32'h0, N, N, 32'h0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         idle(2);
         checkOutput(2, $sformatf("flush after reset %0d", i), N, N, Y, 32'h0, N, Y, NOP);
      end
      checkOutput(1, "L1 after reset", N, N, Y, 32'h0, N, Y, NOP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
